button_scan_debouncer: RTL and testbench

Debounce scheduler for all game push-buttons: paddle up/down for both players, serve, and pause.
- Each button gets its own 2-flop synchronizer.
- All buttons share ONE settle timer, granted round-robin to one button at a time, instead of one counter per button.
- Outputs feed the paddle/serve logic: stable levels plus single-cycle press/release pulses.

---
 rtl/button_scan_debouncer_pkg.sv | 19 +
 rtl/button_scan_debouncer_btn_sync.sv | 23 ++
 rtl/button_scan_debouncer.sv | 106 ++++++++++
 tb/tb_button_scan_debouncer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_scan_debouncer_pkg.sv
// Shared definitions for the button debounce scheduler: FSM encoding,
// default settle width and the round-robin wrap helper.
package button_scan_debouncer_pkg;

    // 2'd3 is unused and steers back to SCAN
    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // 2^19-1 cycles is roughly 10 ms at 50 MHz
    localparam int SETTLE_W_DEFAULT = 19;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/button_scan_debouncer_btn_sync.sv
// Two-flop synchronizer, one chain per raw button input.
module btn_sync #(
    parameter int NUM_BTN = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] raw,
    output logic [NUM_BTN-1:0] sync
);

    logic [NUM_BTN-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

endmodule

// File: rtl/button_scan_debouncer.sv
// Debounces all game buttons with a single settle timer that is handed
// round-robin to whichever button currently disagrees with its stable level.
module button_scan_debouncer
    import button_scan_debouncer_pkg::*;
#(
    parameter int NUM_BTN  = 4,
    parameter int SETTLE_W = SETTLE_W_DEFAULT,
    parameter int IDX_W    = $clog2(NUM_BTN)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] raw,
    output logic [NUM_BTN-1:0] q,
    output logic [NUM_BTN-1:0] rise,
    output logic [NUM_BTN-1:0] fall,
    output logic               busy,
    output logic [IDX_W-1:0]   active_idx
);

    state_t              state;
    logic [IDX_W-1:0]    ptr;
    logic [SETTLE_W-1:0] timer;
    logic [NUM_BTN-1:0]  sync;
    logic [NUM_BTN-1:0]  pending;
    logic                found;
    logic [IDX_W-1:0]    pick;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    next_ptr;

    btn_sync #(.NUM_BTN(NUM_BTN)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (raw),
        .sync    (sync)
    );

    assign pending  = sync ^ q;
    assign next_ptr = IDX_W'(wrap_inc(int'(active_idx), NUM_BTN));

    // First pending button at or after ptr, wrapping past the top index
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_BTN; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_BTN);
            if (!found && pending[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SCAN;
            ptr        <= '0;
            timer      <= '0;
            active_idx <= '0;
            busy       <= 1'b0;
            q          <= '0;
            rise       <= '0;
            fall       <= '0;
        end else begin
            rise <= '0;
            fall <= '0;
            case (state)
                SCAN: begin
                    if (found) begin
                        active_idx <= pick;
                        timer      <= '1;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (pending[active_idx]) begin
                        timer <= timer - SETTLE_W'(1);
                        if (timer == SETTLE_W'(1))
                            state <= COMMIT;
                    end else begin
                        // Bounced back before the window closed: drop it
                        ptr   <= next_ptr;
                        busy  <= 1'b0;
                        state <= SCAN;
                    end
                end
                COMMIT: begin
                    q[active_idx] <= ~q[active_idx];
                    if (q[active_idx])
                        fall[active_idx] <= 1'b1;
                    else
                        rise[active_idx] <= 1'b1;
                    ptr   <= next_ptr;
                    busy  <= 1'b0;
                    state <= SCAN;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_scan_debouncer.sv
// Directed scenarios plus random button traffic, all checked every cycle
// against a transaction-style model of the shared-timer scheduler.
module tb_button_scan_debouncer;

    localparam int NB  = 4;
    localparam int SW  = 3;
    localparam int IW  = 2;
    localparam int WIN = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NB-1:0] raw = '0;
    logic [NB-1:0] q, rise, fall;
    logic          busy;
    logic [IW-1:0] active_idx;

    int total = 0;
    int bad   = 0;

    // Model: raw history for the 2-cycle sync delay, stable levels, owner of the timer
    logic [NB-1:0] m_hist [2];
    logic [NB-1:0] m_q, m_rise, m_fall;
    int            m_ptr, m_own, m_left;

    always #5 clk = ~clk;

    button_scan_debouncer #(.NUM_BTN(NB), .SETTLE_W(SW), .IDX_W(IW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .raw        (raw),
        .q          (q),
        .rise       (rise),
        .fall       (fall),
        .busy       (busy),
        .active_idx (active_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist[0] = '0; m_hist[1] = '0;
        m_q = '0; m_rise = '0; m_fall = '0;
        m_ptr = 0; m_own = -1; m_left = 0;
    endtask

    task automatic model_edge();
        logic [NB-1:0] s;
        if (!reset_n) begin
            model_reset();
            return;
        end
        s = m_hist[1];
        m_rise = '0; m_fall = '0;
        if (m_own < 0) begin
            for (int k = 0; k < NB; k++) begin
                int j;
                j = (m_ptr + k) % NB;
                if (s[j] != m_q[j]) begin
                    m_own = j; m_left = WIN;
                    break;
                end
            end
        end else if (m_left == 0) begin
            m_q[m_own] = ~m_q[m_own];
            if (m_q[m_own]) m_rise[m_own] = 1'b1;
            else            m_fall[m_own] = 1'b1;
            m_ptr = (m_own + 1) % NB;
            m_own = -1;
        end else if (s[m_own] == m_q[m_own]) begin
            m_ptr = (m_own + 1) % NB;
            m_own = -1;
        end else begin
            m_left--;
        end
        m_hist[1] = m_hist[0];
        m_hist[0] = raw;
    endtask

    task automatic compare_model();
        chk("q", 32'(q), 32'(m_q));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("busy", 32'(busy), 32'(m_own >= 0));
        if (m_own >= 0) chk("active_idx", 32'(active_idx), 32'(m_own));
        if (((rise | fall) & ((rise | fall) - 1'b1)) != '0) chk("onehot_pulse", 32'(rise | fall), 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model();
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_rise", 32'(rise), 32'h0);
        chk("rst_fall", 32'(fall), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_idx", 32'(active_idx), 32'h0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Steps until q[idx]==val; returns cycles taken and cycles busy was high
    task automatic wait_q(input int idx, input logic val, output int n, output int nbusy);
        n = 0; nbusy = 0;
        while (n < 60) begin
            step();
            n++;
            if (q[idx] === val) break;
            if (busy) nbusy++;
        end
        if (q[idx] !== val) chk("wait_timeout", 32'(n), 32'hFFFF);
    endtask

    initial begin
        int n, nb, n2;
        logic [NB-1:0] pulses;

        assert_reset();
        repeat (2) step();
        release_reset();
        repeat (3) step();

        // Clean press on button 2
        raw[2] = 1'b1;
        wait_q(2, 1'b1, n, nb);
        chk("t1_latency", 32'(n), 32'd11);
        chk("t1_rise", 32'(rise), 32'b0100);
        chk("t1_fall", 32'(fall), 32'b0000);
        chk("t1_busy_cycles", 32'(nb), 32'd8);
        step();
        chk("t1_rise_done", 32'(rise), 32'b0000);

        // Release of button 2
        raw[2] = 1'b0;
        wait_q(2, 1'b0, n, nb);
        chk("t4_latency", 32'(n), 32'd11);
        chk("t4_fall", 32'(fall), 32'b0100);
        chk("t4_rise", 32'(rise), 32'b0000);
        step();

        // Bounce on button 1: four cycles high, then low
        raw[1] = 1'b1;
        repeat (4) step();
        raw[1] = 1'b0;
        pulses = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            pulses |= rise | fall;
        end
        chk("t2_q", 32'(q), 32'b0000);
        chk("t2_pulses", 32'(pulses), 32'b0000);
        chk("t2_busy", 32'(busy), 32'h0);

        // Simultaneous press of 0 and 3 with ptr back at 0
        assert_reset();
        release_reset();
        raw[0] = 1'b1; raw[3] = 1'b1;
        wait_q(0, 1'b1, n, nb);
        chk("t3_first", 32'(n), 32'd11);
        chk("t3_rise0", 32'(rise), 32'b0001);
        wait_q(3, 1'b1, n2, nb);
        chk("t3_second", 32'(n2), 32'd9);
        chk("t3_rise3", 32'(rise), 32'b1000);
        step();

        // Wrap: after committing button 3, buttons 0 and 2 pend together
        raw[0] = 1'b0; raw[2] = 1'b1;
        wait_q(0, 1'b0, n, nb);
        chk("t6_first_is_0", 32'(q[2]), 32'h0);
        chk("t6_fall0", 32'(fall), 32'b0001);
        wait_q(2, 1'b1, n2, nb);
        chk("t6_second", 32'(n2), 32'd9);
        step();

        // Reset during the 5th SETTLE cycle of button 1; raw held through reset
        raw = '0;
        assert_reset();
        release_reset();
        raw[1] = 1'b1;
        repeat (7) step();
        chk("t5_busy_before", 32'(busy), 32'h1);
        chk("t5_idx_before", 32'(active_idx), 32'h1);
        assert_reset();
        repeat (2) step();
        release_reset();
        wait_q(1, 1'b1, n, nb);
        chk("t5_latency", 32'(n), 32'd11);
        chk("t5_rise", 32'(rise), 32'b0010);

        // Random traffic with occasional long holds and one async reset
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) raw[$urandom_range(0, NB - 1)] ^= 1'b1;
            if (c == 300) begin
                #2;
                assert_reset();
                release_reset();
            end
            step();
        end
        raw = '0;
        repeat (60) step();
        chk("final_q", 32'(q), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
